exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the Thumb-2 core, directly downstream of the decode/operand-fetch stage.
- Consumes oprand1, oprand2, destination register address, opcode and shifter/immediate carry-out.
- Computes the ALU or multiply result, or a 32-step iterative divide.
- Presents a registered writeback to the register file plus N/Z/C/V flag updates to xpsr_reg.
- Stalls decode through a valid/ready handshake while a divide is in flight.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- ADDR_W, 4, register address width.
- DIV_STEPS, 32, iterations per divide; must equal DATA_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (low = reset).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- op  in  5  0x00 AND, 01 EOR, 02 SUB, 03 RSB, 04 ADD, 05 ADC, 06 SBC, 07 MUL, 08 TST, 09 TEQ, 0A CMP, 0B CMN, 0C ORR, 0D MOV, 0E BIC, 0F MVN, 10 UDIV, 11 SDIV; 12–1F reserved.
- oprand1  in  32  first operand (Rn).
- oprand2  in  32  second operand (shifted register or expanded immediate).
- rd_addr  in  4  destination register.
- set_flags  in  1  instruction updates APSR.
- carry_in  in  1  current APSR.C.
- shift_carry  in  1  carry-out of shifter/immediate expansion.
- flush  in  1  kill in-flight and presented work.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_addr  out  4  writeback register.
- wb_data  out  32  writeback value.
- flags_en  out  1  apply flags this cycle; pulses with wb_valid.
- flags_nzcv  out  4  {N,Z,C,V}.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; in_ready=0 while rst low, 1 from the first edge after release; wb_valid=0, wb_addr=0, wb_data=0, flags_en=0, flags_nzcv=0; divider registers cleared.
- Accept: in_valid && in_ready && !flush at a rising edge.
- Single-cycle ops (00–0F, reserved, divide-by-zero): wb_valid is high in the cycle after accept; back-to-back accepts allowed every cycle.
- Adder: ADD a+b; ADC a+b+carry_in; SUB/CMP a+~b+1; SBC a+~b+carry_in; RSB b+~a+1; CMN a+b. C = 33rd bit; V = signed overflow.
- Logical ops (AND/EOR/ORR/BIC/MOV/MVN/TST/TEQ): C=shift_carry, V=carry_in is held (flags_nzcv[0] returns the current V is not available, so V output = 0 and flag V-enable masked: the V flag is left unchanged by xpsr_reg for logical ops).
- MUL: low 32 bits of a*b; C and V unchanged (same masking as V above).
- N = result[31]; Z = (result==0).
- TST/TEQ/CMP/CMN: wb_valid=0; flags_en=1.
- Other ops: flags_en = set_flags.
- Reserved ops: no writeback, flags_en=0, still consume one slot.
- Divide: states IDLE → DIV_BUSY → DIV_DONE → IDLE.
  - On accept with oprand2≠0: latch magnitudes, signs and rd_addr; in_ready=0; restoring shift-subtract, one quotient bit per cycle for DIV_STEPS cycles in DIV_BUSY.
  - DIV_DONE applies sign correction (SDIV quotient negated if signs differ) and asserts wb_valid; in_ready returns high in DIV_DONE.
  - Result appears 33 cycles after accept; divide never updates flags (flags_en=0).
  - oprand2==0: result 0 in one cycle, no busy state.
  - SDIV 0x80000000 / 0xFFFFFFFF = 0x80000000.
- Flush: combinationally blocks accept this cycle; in DIV_BUSY/DIV_DONE returns to IDLE next edge with no wb_valid. A single-cycle result already registered still writes back.
- Reset mid-divide: abort immediately, no writeback.

Optional Feature:
- HW_DIV_EN defined: UDIV/SDIV execute as above.
- Undefined: divider and its states are not built; ops 10/11 behave as reserved (no writeback, one cycle); in_ready is high at all times outside reset.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, set_flags=1, rd=3 → next cycle wb_valid=1, wb_addr=3, wb_data=0, NZCV=0110.
- SUB 0x80000000−0x00000001, set_flags=1 → wb_data=0x7FFFFFFF, NZCV=0011; CMP with same operands → wb_valid=0, flags_en=1, same flags.
- UDIV 100/7 held with in_valid=1 → in_ready low 32 cycles, wb_data=0x0000000E exactly 33 cycles after accept, next instruction accepted in DIV_DONE.
- SDIV 0xFFFFFFF9/2 → 0xFFFFFFFD; SDIV 0x80000000/0xFFFFFFFF → 0x80000000; UDIV 5/0 → 0 one cycle later.
- UDIV accepted, flush at cycle 10 → no wb_valid, in_ready=1 next cycle; repeat with rst low at cycle 10 → outputs zero immediately.
- Back-to-back ADC 1+1 (carry_in=1) then MVN 0 → wb_data 3 then 0xFFFFFFFF on consecutive cycles, no bubbles.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: Thumb-2 execute stage computing ALU/MUL results and an optional iterative divide, with registered writeback and NZCV updates.
// Ports: clk, rst (async, active-low); in_valid/in_ready handshake from decode;
//        op, oprand1, oprand2, rd_addr, set_flags, carry_in, shift_carry instruction inputs; flush kills work;
//        wb_valid/wb_addr/wb_data register-file writeback; flags_en/flags_nzcv {N,Z,C,V} update toward xpsr_reg.
// Macro HW_DIV_EN builds the 32-step restoring UDIV/SDIV unit; without it ops 0x10/0x11 behave as reserved.
module exec_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] oprand1,
    input  logic [DATA_W-1:0] oprand2,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              set_flags,
    input  logic              carry_in,
    input  logic              shift_carry,
    input  logic              flush,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flags_en,
    output logic [3:0]        flags_nzcv
);
    if (DATA_W != 32 || DIV_STEPS != DATA_W) begin : g_bad_cfg
        $error("exec_stage supports only DATA_W=32 and DIV_STEPS=DATA_W");
    end

    logic              accept, rdy_q;
    logic [DATA_W-1:0] x, y, res, wdat;
    logic              cin, inv_b, rsb, arith, cmp_op, alu_op, div_op, div_zero, wr, fen;
    logic [DATA_W:0]   sum;
    logic [3:0]        nzcv;
    logic              wb_q, fen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        nzcv_q;

    assign accept = in_valid && in_ready && !flush;

`ifdef HW_DIV_EN
    assign div_op = op == 5'h10 || op == 5'h11;
`else
    assign div_op = 1'b0;
`endif

    // One shared adder covers every arithmetic op by steering operand inversion and carry-in.
    always_comb begin
        rsb    = op == 5'h03;
        inv_b  = op == 5'h02 || op == 5'h06 || op == 5'h0A;
        arith  = op inside {5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h0A, 5'h0B};
        cmp_op = op inside {5'h08, 5'h09, 5'h0A, 5'h0B};
        alu_op = op < 5'h10;
        x      = rsb ? oprand2 : oprand1;
        y      = rsb ? ~oprand1 : inv_b ? ~oprand2 : oprand2;
        cin    = (op == 5'h02 || op == 5'h03 || op == 5'h0A) ? 1'b1 :
                 (op == 5'h05 || op == 5'h06) ? carry_in : 1'b0;
        sum    = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
        case (op)
            5'h00, 5'h08: res = oprand1 & oprand2;
            5'h01, 5'h09: res = oprand1 ^ oprand2;
            5'h07:        res = oprand1 * oprand2;
            5'h0C:        res = oprand1 | oprand2;
            5'h0D:        res = oprand2;
            5'h0E:        res = oprand1 & ~oprand2;
            5'h0F:        res = ~oprand2;
            default:      res = sum[DATA_W-1:0];
        endcase
        // MUL and logical ops report V=0 (and MUL C=0); xpsr_reg leaves those bits unchanged for them.
        nzcv     = {res[DATA_W-1], res == '0,
                    arith ? sum[DATA_W] : (op != 5'h07 && shift_carry),
                    arith && x[DATA_W-1] == y[DATA_W-1] && sum[DATA_W-1] != x[DATA_W-1]};
        div_zero = div_op && oprand2 == '0;
        wr       = (alu_op && !cmp_op) || div_zero;
        fen      = cmp_op || (alu_op && set_flags);
        wdat     = div_zero ? '0 : res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            wb_q   <= 1'b0;
            fen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            nzcv_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            wb_q  <= accept && wr;
            fen_q <= accept && fen;
            if (accept && (wr || fen)) begin
                addr_q <= rd_addr;
                data_q <= wdat;
                nzcv_q <= nzcv;
            end
        end
    end

`ifdef HW_DIV_EN
    typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;
    localparam int CW = $clog2(DIV_STEPS);

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] q, r, d, a_mag, b_mag;
    logic [DATA_W:0]   rem_sh;
    logic              neg, ge, sdiv, div_start;
    logic [ADDR_W-1:0] div_addr;

    assign sdiv      = op == 5'h11;
    assign div_start = accept && div_op && !div_zero;
    assign a_mag     = (sdiv && oprand1[DATA_W-1]) ? -oprand1 : oprand1;
    assign b_mag     = (sdiv && oprand2[DATA_W-1]) ? -oprand2 : oprand2;
    // q doubles as the dividend shift register: its MSB feeds the partial remainder, quotient bits enter at the LSB.
    assign rem_sh    = {r, q[DATA_W-1]};
    assign ge        = rem_sh >= {1'b0, d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state == DIV_BUSY ? (flush ? IDLE : cnt == CW'(DIV_STEPS - 1) ? DIV_DONE : DIV_BUSY) :
              div_start ? DIV_BUSY : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            d        <= '0;
            neg      <= 1'b0;
            div_addr <= '0;
        end else if (div_start) begin
            cnt      <= '0;
            q        <= a_mag;
            r        <= '0;
            d        <= b_mag;
            neg      <= sdiv && (oprand1[DATA_W-1] ^ oprand2[DATA_W-1]);
            div_addr <= rd_addr;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 1'b1;
            r   <= ge ? DATA_W'(rem_sh - {1'b0, d}) : rem_sh[DATA_W-1:0];
            q   <= {q[DATA_W-2:0], ge};
        end
    end

    // DIV_DONE drives the writeback straight from the divider; nothing single-cycle can be pending then.
    always_comb begin
        in_ready   = rdy_q && state != DIV_BUSY;
        wb_valid   = state == DIV_DONE ? !flush : wb_q;
        wb_addr    = state == DIV_DONE ? div_addr : addr_q;
        wb_data    = state == DIV_DONE ? (neg ? -q : q) : data_q;
        flags_en   = fen_q;
        flags_nzcv = nzcv_q;
    end
`else
    always_comb begin
        in_ready   = rdy_q;
        wb_valid   = wb_q;
        wb_addr    = addr_q;
        wb_data    = data_q;
        flags_en   = fen_q;
        flags_nzcv = nzcv_q;
    end
`endif
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed self-checking bench for exec_stage (divide steps only when HW_DIV_EN is defined).
module tb_exec_stage;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, set_flags = 1'b0;
    logic        carry_in = 1'b0, shift_carry = 1'b0, flush = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] oprand1 = '0, oprand2 = '0;
    logic [3:0]  rd_addr = '0;
    logic        in_ready, wb_valid, flags_en;
    logic [3:0]  wb_addr, flags_nzcv;
    logic [31:0] wb_data;
    int          checks = 0, failures = 0;
    logic        seen;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .oprand1(oprand1), .oprand2(oprand2), .rd_addr(rd_addr), .set_flags(set_flags),
        .carry_in(carry_in), .shift_carry(shift_carry), .flush(flush), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .flags_en(flags_en), .flags_nzcv(flags_nzcv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic sf, input logic ci, input logic sc);
        in_valid    = 1'b1;
        op          = o;
        oprand1     = a;
        oprand2     = b;
        rd_addr     = rd;
        set_flags   = sf;
        carry_in    = ci;
        shift_carry = sc;
    endtask

    task automatic div_run(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] rd, input logic [31:0] exp);
        drive(o, a, b, rd, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (31) @(negedge clk);
        chk("div_not_early", wb_valid, 1'b0);
        @(negedge clk);
        chk("div_valid", wb_valid, 1'b1);
        chk("div_addr", wb_addr, rd);
        chk("div_data", wb_data, exp);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_addr", wb_addr, 4'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_flags_en", flags_en, 1'b0);
        chk("rst_nzcv", flags_nzcv, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1'b1);

        drive(5'h04, 32'hFFFF_FFFF, 32'h1, 4'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_valid", wb_valid, 1'b1);
        chk("add_addr", wb_addr, 4'd3);
        chk("add_data", wb_data, 32'h0);
        chk("add_fen", flags_en, 1'b1);
        chk("add_nzcv", flags_nzcv, 4'b0110);

        drive(5'h02, 32'h8000_0000, 32'h1, 4'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_valid", wb_valid, 1'b1);
        chk("sub_data", wb_data, 32'h7FFF_FFFF);
        chk("sub_nzcv", flags_nzcv, 4'b0011);

        drive(5'h0A, 32'h8000_0000, 32'h1, 4'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cmp_valid", wb_valid, 1'b0);
        chk("cmp_fen", flags_en, 1'b1);
        chk("cmp_nzcv", flags_nzcv, 4'b0011);

        drive(5'h05, 32'h1, 32'h1, 4'd1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("adc_valid", wb_valid, 1'b1);
        chk("adc_data", wb_data, 32'h3);
        chk("adc_fen", flags_en, 1'b0);

        drive(5'h0F, 32'h0, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("mvn_valid", wb_valid, 1'b1);
        chk("mvn_addr", wb_addr, 4'd2);
        chk("mvn_data", wb_data, 32'hFFFF_FFFF);
        chk("mvn_nzcv", flags_nzcv, 4'b1010);

        drive(5'h07, 32'h0001_0000, 32'h0001_0001, 4'd4, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("mul_data", wb_data, 32'h0001_0000);
        chk("mul_nzcv", flags_nzcv, 4'b0000);

        drive(5'h08, 32'hF0, 32'h0F, 4'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("tst_valid", wb_valid, 1'b0);
        chk("tst_fen", flags_en, 1'b1);
        chk("tst_nzcv", flags_nzcv, 4'b0100);

        drive(5'h15, 32'h1, 32'h1, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rsvd_valid", wb_valid, 1'b0);
        chk("rsvd_fen", flags_en, 1'b0);
        chk("rsvd_ready", in_ready, 1'b1);

        drive(5'h04, 32'h1, 32'h2, 4'd7, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_block_valid", wb_valid, 1'b0);
        chk("flush_block_fen", flags_en, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("flush_keeps_wb", wb_valid, 1'b1);
        chk("flush_keeps_data", wb_data, 32'h3);
        flush = 1'b0;
        @(negedge clk);

`ifdef HW_DIV_EN
        drive(5'h10, 32'd100, 32'd7, 4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk("udiv_busy", {in_ready, wb_valid}, 2'b00);
        end
        @(negedge clk);
        chk("udiv_valid", wb_valid, 1'b1);
        chk("udiv_addr", wb_addr, 4'd8);
        chk("udiv_data", wb_data, 32'h0000_000E);
        chk("udiv_ready_done", in_ready, 1'b1);
        chk("udiv_fen", flags_en, 1'b0);
        drive(5'h04, 32'd5, 32'd6, 4'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_div_valid", wb_valid, 1'b1);
        chk("after_div_data", wb_data, 32'd11);
        chk("after_div_addr", wb_addr, 4'd9);

        div_run(5'h11, 32'hFFFF_FFF9, 32'h2, 4'd10, 32'hFFFF_FFFD);
        div_run(5'h11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h8000_0000);
        div_run(5'h10, 32'hFFFF_FFFF, 32'h1, 4'd12, 32'hFFFF_FFFF);

        drive(5'h10, 32'd5, 32'd0, 4'd10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("div0_valid", wb_valid, 1'b1);
        chk("div0_data", wb_data, 32'h0);
        chk("div0_ready", in_ready, 1'b1);
        chk("div0_fen", flags_en, 1'b0);

        drive(5'h10, 32'd1000, 32'd3, 4'd11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("div_flush_ready", in_ready, 1'b1);
        chk("div_flush_valid", wb_valid, 1'b0);
        flush = 1'b0;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
        end
        chk("div_flush_no_wb", seen, 1'b0);

        drive(5'h02, 32'h1, 32'h2, 4'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_data", wb_data, 32'hFFFF_FFFF);
        chk("pre_rst_nzcv", flags_nzcv, 4'b1000);
        drive(5'h10, 32'd1000, 32'd3, 4'd12, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", wb_valid, 1'b0);
        chk("mid_rst_data", wb_data, 32'h0);
        chk("mid_rst_addr", wb_addr, 4'h0);
        chk("mid_rst_ready", in_ready, 1'b0);
        chk("mid_rst_nzcv", flags_nzcv, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
        end
        chk("mid_rst_no_wb", seen, 1'b0);
        chk("mid_rst_ready_again", in_ready, 1'b1);
`else
        drive(5'h10, 32'd100, 32'd7, 4'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("nodiv_valid", wb_valid, 1'b0);
        chk("nodiv_fen", flags_en, 1'b0);
        chk("nodiv_ready", in_ready, 1'b1);
        drive(5'h04, 32'd5, 32'd6, 4'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("nodiv_next_valid", wb_valid, 1'b1);
        chk("nodiv_next_data", wb_data, 32'd11);
`endif

        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid", wb_valid, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
